// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and state encoding for the memory controller.
`default_nettype none

package mem_pkg;

  localparam int DATA_W      = 32;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_WR_WAIT = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_WAIT = ST_RD_WAIT,
    WR_WAIT = ST_WR_WAIT,
    DONE    = ST_DONE,
    ERR     = ST_ERR
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_wait_timer.sv
// wait_timer: clearable wait counter; expired flags the last allowed wait cycle.
`default_nettype none

module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// mem_ctrl: ready-handshake read/write sequencer between MAR/MDR and a
// variable-latency RAM, with timeout and illegal-request detection.
`default_nettype none

module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata_out,
  output logic              read_sel,
  output logic              mdr_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  state_t              state, state_n;
  logic                done_n, err_n, read_sel_n, mdr_load_n;
  logic                mem_re_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [31:0]         mem_wdata_n, rdata_n;
  logic                timer_clear, timer_en, expired;
  logic                addr_bad;

  assign addr_bad = (addr_in[31:ADDR_W] != '0);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_n     = state;
    done_n      = 1'b0;
    err_n       = 1'b0;
    read_sel_n  = 1'b0;
    mdr_load_n  = 1'b0;
    mem_re_n    = mem_re;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rdata_n     = rdata_out;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state)
      IDLE: begin
        // Holding the timer clear here makes every WAIT entry start at zero.
        timer_clear = 1'b1;
        if (rd_req || wr_req) begin
          if ((rd_req && wr_req) || addr_bad) begin
            state_n = ERR;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else if (rd_req) begin
            state_n    = RD_WAIT;
            mem_addr_n = addr_in[ADDR_W-1:0];
            mem_re_n   = 1'b1;
          end else begin
            state_n     = WR_WAIT;
            mem_addr_n  = addr_in[ADDR_W-1:0];
            mem_wdata_n = wdata_in;
            mem_we_n    = 1'b1;
          end
        end
      end

      RD_WAIT: begin
        if (mem_ready) begin
          state_n    = DONE;
          mem_re_n   = 1'b0;
          rdata_n    = mem_rdata;
          done_n     = 1'b1;
          read_sel_n = 1'b1;
          mdr_load_n = 1'b1;
        end else if (expired) begin
          state_n  = ERR;
          mem_re_n = 1'b0;
          done_n   = 1'b1;
          err_n    = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end

      WR_WAIT: begin
        if (mem_ready) begin
          state_n  = DONE;
          mem_we_n = 1'b0;
          done_n   = 1'b1;
        end else if (expired) begin
          state_n  = ERR;
          mem_we_n = 1'b0;
          done_n   = 1'b1;
          err_n    = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end

      DONE, ERR: begin
        state_n = IDLE;
      end

      default: begin
        state_n  = IDLE;
        mem_re_n = 1'b0;
        mem_we_n = 1'b0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      read_sel  <= 1'b0;
      mdr_load  <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_out <= '0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
      err       <= err_n;
      read_sel  <= read_sel_n;
      mdr_load  <= mdr_load_n;
      mem_re    <= mem_re_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      rdata_out <= rdata_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a done-triggered scoreboard monitor.
`default_nettype none

module tb_mem_ctrl;

  localparam int AW  = 9;
  localparam int TMO = 16;

  typedef struct {
    bit          err;
    bit          rsel;
    logic [31:0] rdata;
    int          en;
    bit          is_wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   addr_in = '0, wdata_in = '0;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic          busy, done, err, read_sel, mdr_load, mem_re, mem_we;
  logic [31:0]   rdata_out, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;

  logic [31:0]   ram [0:511];
  exp_t          sb[$];
  int            checks = 0, failures = 0;
  logic [31:0]   last_rdata = '0;

  // RAM responder state
  int            wait_cycles = 0;
  int            en_cnt = 0, last_en = 0;
  logic [8:0]    addr_seen;
  logic [31:0]   wdata_seen;
  bit            re_seen = 0, we_seen = 0, unstable = 0;

  assign mem_rdata = ram[mem_addr];

  mem_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
    .rd_req(rd_req), .wr_req(wr_req), .busy(busy), .done(done), .err(err),
    .rdata_out(rdata_out), .read_sel(read_sel), .mdr_load(mdr_load),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RAM: ready arrives in enable cycle number wait_cycles (-1 = never).
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_re || mem_we) begin
        if (en_cnt == 0) begin
          addr_seen = mem_addr; wdata_seen = mem_wdata;
          re_seen = mem_re; we_seen = mem_we;
        end else if (mem_addr != addr_seen || mem_wdata != wdata_seen ||
                     mem_re != re_seen || mem_we != we_seen) begin
          unstable = 1;
        end
        mem_ready = (en_cnt == wait_cycles);
        if (mem_ready && mem_we) ram[mem_addr] = mem_wdata;
        en_cnt++;
      end else begin
        mem_ready = 1'b0;
        if (en_cnt != 0) last_en = en_cnt;
        en_cnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("read_sel", {31'd0, read_sel}, {31'd0, e.rsel});
          chk("mdr_load", {31'd0, mdr_load}, {31'd0, e.rsel});
          chk("rdata_out", rdata_out, e.rdata);
          chk("enable_cycles", last_en, e.en);
          if (e.en > 0) begin
            chk("ram_addr", {23'd0, addr_seen}, {23'd0, e.addr});
            chk("we_used", {31'd0, we_seen}, {31'd0, e.is_wr});
            chk("re_used", {31'd0, re_seen}, {31'd0, !e.is_wr});
            chk("stable", {31'd0, unstable}, 32'd0);
            if (e.is_wr) chk("ram_wdata", wdata_seen, e.wdata);
          end
        end
        last_en = 0;
        unstable = 0;
      end else if (!reset && (err || read_sel || mdr_load)) begin
        chk("stray_pulse", {29'd0, err, read_sel, mdr_load}, 32'd0);
      end
    end
  end

  // waitc: enable cycle in which ready rises (-1 never); poke: extra rd_req while busy.
  task automatic xact(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input int waitc, input bit poke,
                      input int exp_lat);
    exp_t e;
    int   lat;
    bit   illegal;
    illegal = (rd && wr) || (a[31:AW] != 0);
    e.is_wr = wr && !rd;
    e.addr  = a[8:0];
    e.wdata = wd;
    if (illegal) begin
      e.err = 1; e.rsel = 0; e.rdata = last_rdata; e.en = 0;
    end else if (waitc < 0 || waitc >= TMO) begin
      e.err = 1; e.rsel = 0; e.rdata = last_rdata; e.en = TMO;
    end else begin
      e.err = 0; e.rsel = rd; e.en = waitc + 1;
      e.rdata = rd ? ram[a[8:0]] : last_rdata;
    end
    last_rdata = e.rdata;
    sb.push_back(e);
    wait_cycles = waitc;
    addr_in = a; wdata_in = wd; rd_req = rd; wr_req = wr;
    @(posedge clk); #1;
    rd_req = 0; wr_req = 0;
    lat = 1;
    while (!done && lat < 60) begin
      rd_req = poke && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    rd_req = poke;
    chk("latency", lat, exp_lat);
    @(posedge clk); #1;
    rd_req = 0;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'h0;
    ram[5]    = 32'hCAFE0001;
    ram[7]    = 32'h00000777;
    ram[9'h20] = 32'hA5A50020;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_enables", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 0;
    @(posedge clk); #1;

    xact(1, 0, 32'd5,        32'd0,         0,  0, 2);   // zero-wait read
    xact(0, 1, 32'h10,       32'h12345678,  3,  0, 5);   // 3-wait write
    xact(1, 0, 32'h10,       32'd0,         1,  0, 3);   // read back the write
    xact(1, 0, 32'd7,        32'd0,        -1,  0, 17);  // timeout
    xact(1, 0, 32'd7,        32'd0,        15,  0, 17);  // ready in last allowed cycle
    xact(1, 1, 32'd5,        32'd0,         0,  0, 1);   // rd+wr together
    xact(1, 0, 32'h00000200, 32'd0,         0,  0, 1);   // out of range
    xact(0, 1, 32'h80000000, 32'hDEAD,      0,  0, 1);   // out of range write
    xact(1, 0, 32'h20,       32'd0,         3,  1, 5);   // requests while busy ignored
    xact(1, 0, 32'd5,        32'd0,         0,  0, 2);   // accepted right after

    // reset during the second WR_WAIT cycle
    wait_cycles = -1;
    addr_in = 32'h30; wdata_in = 32'h55AA55AA; wr_req = 1;
    @(posedge clk); #1; wr_req = 0;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    chk("rstmid_we", {31'd0, mem_we}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_rdata", rdata_out, 32'd0);
    last_rdata = 32'd0;
    last_en = 0; unstable = 0;
    repeat (4) @(posedge clk);
    #1;
    xact(1, 0, 32'h20, 32'd0, 0, 0, 2);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
